// File: rtl/johnson_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : johnson_counter_n
// Brief    : Parametrised Johnson (twisted-ring) counter, WIDTH flops,
//            2*WIDTH phases. Count enable, up/down, synchronous phase load,
//            binary phase output, wrap strobe and illegal-state recovery.
//            Optional one-hot phase decode on port DEC when the macro
//            JOHNSON_DECODE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module johnson_counter_n #(
    parameter int WIDTH = 2,
    parameter int INIT  = 0,
    localparam int PW   = $clog2(2*WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [PW-1:0]    LOAD_PHASE,
    output logic [WIDTH-1:0] O,
    output logic [PW-1:0]    PHASE,
    output logic             WRAP,
    output logic             ERR
`ifdef JOHNSON_DECODE_EN
    ,
    output logic [2*WIDTH-1:0] DEC
`endif
);

    localparam int            c_NPH  = 2*WIDTH;
    localparam logic [PW-1:0] c_LAST = PW'(c_NPH - 1);
    localparam logic [PW-1:0] c_INIT = PW'(INIT);

    // Ring code of phase k: a run of ones growing from the LSB for k <= WIDTH,
    // then a run of zeros growing from the LSB for the second half-cycle.
    function automatic logic [WIDTH-1:0] f_encode(input int k);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (k <= WIDTH) v[i] = (i < k);
            else            v[i] = (i >= k - WIDTH);
        end
        return v;
    endfunction

    localparam logic [WIDTH-1:0] c_INIT_O = f_encode(INIT);

    logic [WIDTH-1:0] r_o;
    logic [PW-1:0]    r_phase;
    logic             r_err;

    logic [WIDTH-1:0] w_o_nxt;
    logic [PW-1:0]    w_ph_nxt;
    logic             w_err_nxt;
    logic [WIDTH-2:0] w_edges;
    logic             w_illegal;
    logic [31:0]      w_lp32;
    logic             w_load_bad;

    // A valid Johnson code has at most one 0/1 boundary between adjacent bits.
    assign w_edges    = r_o[WIDTH-1:1] ^ r_o[WIDTH-2:0];
    assign w_illegal  = (w_edges & (w_edges - (WIDTH-1)'(1))) != '0;

    // Widened copy so the range test stays meaningful for every WIDTH.
    assign w_lp32     = 32'(LOAD_PHASE);
    assign w_load_bad = (w_lp32 >= 32'(c_NPH));

    // Next-state selection: recovery > load > count > hold (reset in the flop).
    always_comb begin
        w_o_nxt   = r_o;
        w_ph_nxt  = r_phase;
        w_err_nxt = 1'b0;
        if (w_illegal) begin
            w_o_nxt   = '0;
            w_ph_nxt  = '0;
            w_err_nxt = 1'b1;
        end else if (LOAD) begin
            if (w_load_bad) begin
                w_o_nxt   = '0;
                w_ph_nxt  = '0;
                w_err_nxt = 1'b1;
            end else begin
                w_o_nxt  = f_encode(int'(LOAD_PHASE));
                w_ph_nxt = LOAD_PHASE;
            end
        end else if (CE) begin
            if (UP) begin
                w_o_nxt  = {r_o[WIDTH-2:0], ~r_o[WIDTH-1]};
                w_ph_nxt = (r_phase == c_LAST) ? '0 : r_phase + PW'(1);
            end else begin
                w_o_nxt  = {~r_o[0], r_o[WIDTH-1:1]};
                w_ph_nxt = (r_phase == '0) ? c_LAST : r_phase - PW'(1);
            end
        end
    end

    // State registers with synchronous reset to the INIT phase.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_o     <= c_INIT_O;
            r_phase <= c_INIT;
            r_err   <= 1'b0;
        end else begin
            r_o     <= w_o_nxt;
            r_phase <= w_ph_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign O     = r_o;
    assign PHASE = r_phase;
    assign ERR   = r_err;

    // Strobe for the cycle whose edge takes the phase across the 0 boundary.
    assign WRAP = CE & ~LOAD & ~RESET & (UP ? (r_phase == c_LAST) : (r_phase == '0));

`ifdef JOHNSON_DECODE_EN
    // Each decode bit looks at one adjacent bit pair only, so a single-bit
    // ring step can never produce a spurious pulse.
    genvar k;
    generate
        for (k = 0; k < 2*WIDTH; k++) begin : g_dec
            if (k == 0) begin : g_empty
                assign DEC[k] = ~r_o[WIDTH-1] & ~r_o[0];
            end else if (k < WIDTH) begin : g_rise
                assign DEC[k] = r_o[k-1] & ~r_o[k];
            end else if (k == WIDTH) begin : g_full
                assign DEC[k] = r_o[WIDTH-1] & r_o[0];
            end else begin : g_fall
                assign DEC[k] = ~r_o[k-WIDTH-1] & r_o[k-WIDTH];
            end
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_johnson_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_johnson_counter_n
// Brief    : Directed self-checking bench for johnson_counter_n using three
//            instances (WIDTH = 2, 4 and 3 with INIT = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_johnson_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // WIDTH=2 instance
    logic       r2_rst = 1'b0, r2_ce = 1'b0, r2_up = 1'b1, r2_ld = 1'b0;
    logic [1:0] r2_lp = '0;
    logic [1:0] w2_o;
    logic [1:0] w2_ph;
    logic       w2_wrap, w2_err;
    // WIDTH=4 instance
    logic       r4_rst = 1'b0, r4_ce = 1'b0, r4_up = 1'b1, r4_ld = 1'b0;
    logic [2:0] r4_lp = '0;
    logic [3:0] w4_o;
    logic [2:0] w4_ph;
    logic       w4_wrap, w4_err;
    // WIDTH=3, INIT=2 instance
    logic       r3_rst = 1'b0, r3_ce = 1'b0, r3_up = 1'b1, r3_ld = 1'b0;
    logic [2:0] r3_lp = '0;
    logic [2:0] w3_o;
    logic [2:0] w3_ph;
    logic       w3_wrap, w3_err;
`ifdef JOHNSON_DECODE_EN
    logic [3:0] w2_dec;
    logic [7:0] w4_dec;
    logic [5:0] w3_dec;
`endif

    johnson_counter_n #(.WIDTH(2), .INIT(0)) u_w2 (
        .CLK(clk), .RESET(r2_rst), .CE(r2_ce), .UP(r2_up), .LOAD(r2_ld),
        .LOAD_PHASE(r2_lp), .O(w2_o), .PHASE(w2_ph), .WRAP(w2_wrap), .ERR(w2_err)
`ifdef JOHNSON_DECODE_EN
        , .DEC(w2_dec)
`endif
    );

    johnson_counter_n #(.WIDTH(4), .INIT(0)) u_w4 (
        .CLK(clk), .RESET(r4_rst), .CE(r4_ce), .UP(r4_up), .LOAD(r4_ld),
        .LOAD_PHASE(r4_lp), .O(w4_o), .PHASE(w4_ph), .WRAP(w4_wrap), .ERR(w4_err)
`ifdef JOHNSON_DECODE_EN
        , .DEC(w4_dec)
`endif
    );

    johnson_counter_n #(.WIDTH(3), .INIT(2)) u_w3 (
        .CLK(clk), .RESET(r3_rst), .CE(r3_ce), .UP(r3_up), .LOAD(r3_ld),
        .LOAD_PHASE(r3_lp), .O(w3_o), .PHASE(w3_ph), .WRAP(w3_wrap), .ERR(w3_err)
`ifdef JOHNSON_DECODE_EN
        , .DEC(w3_dec)
`endif
    );

    typedef struct {
        logic       rst, ce, up, ld;
        logic [2:0] lp;
        logic [3:0] o;
        logic [2:0] ph;
        logic       wrap, err;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One active edge, then settle so registered outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string nm, input logic [2:0] o, input logic [2:0] ph, input logic err);
        chk({nm, ".O"},     32'(w3_o),   32'(o));
        chk({nm, ".PHASE"}, 32'(w3_ph),  32'(ph));
        chk({nm, ".ERR"},   32'(w3_err), 32'(err));
    endtask

    // Hard stop in case anything ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] w2_exp [6];
        logic       w2_wexp[5];
        logic [3:0] prev;

        w2_exp  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        w2_wexp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        //            rst   ce    up    ld    lp    O        PH    wrap  err
        tv[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1000, 3'd7, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1100, 3'd6, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1110, 3'd5, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1111, 3'd4, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0111, 3'd3, 1'b0, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b1111, 3'd4, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 4'b1110, 3'd5, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 4'b1000, 3'd7, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b1, 1'b0};
        tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0, 1'b0};
        tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0, 1'b0};
        tv[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 4'b0000, 3'd0, 1'b0, 1'b0};
        tv[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1000, 3'd7, 1'b1, 1'b0};

        // Common reset of all instances.
        @(negedge clk);
        r2_rst = 1'b1; r4_rst = 1'b1; r3_rst = 1'b1;
        tick();
        @(negedge clk);
        r2_rst = 1'b0; r4_rst = 1'b0; r3_rst = 1'b0;
        chk("w2.reset.O",     32'(w2_o),  32'(2'b00));
        chk("w2.reset.PHASE", 32'(w2_ph), 32'(2'd0));
        chk("w2.reset.ERR",   32'(w2_err), 32'(1'b0));
        chk3("w3.reset", 3'b011, 3'd2, 1'b0);

        // WIDTH=2 forward run through the wrap.
        r2_ce = 1'b1; r2_up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("w2.step%0d.WRAP", i), 32'(w2_wrap), 32'(w2_wexp[i]));
            tick();
            chk($sformatf("w2.step%0d.O", i), 32'(w2_o), 32'(w2_exp[i+1]));
            @(negedge clk);
        end
        r2_ce = 1'b0;

        // WIDTH=4 vector table.
        for (int i = 0; i < 14; i++) begin
            r4_rst = tv[i].rst; r4_ce = tv[i].ce; r4_up = tv[i].up;
            r4_ld  = tv[i].ld;  r4_lp = tv[i].lp;
            #1;
            chk($sformatf("w4[%0d].WRAP", i), 32'(w4_wrap), 32'(tv[i].wrap));
            prev = w4_o;
            tick();
            chk($sformatf("w4[%0d].O", i),     32'(w4_o),   32'(tv[i].o));
            chk($sformatf("w4[%0d].PHASE", i), 32'(w4_ph),  32'(tv[i].ph));
            chk($sformatf("w4[%0d].ERR", i),   32'(w4_err), 32'(tv[i].err));
            if (tv[i].ce && !tv[i].ld && !tv[i].rst)
                chk($sformatf("w4[%0d].gray", i), 32'($countones(prev ^ w4_o)), 32'd1);
            @(negedge clk);
        end
        r4_ce = 1'b0; r4_ld = 1'b0; r4_rst = 1'b0;

        // WIDTH=3: count, then reset beats simultaneous load and count.
        r3_ce = 1'b1; r3_up = 1'b1;
        tick(); chk3("w3.fwd1", 3'b111, 3'd3, 1'b0); @(negedge clk);
        tick(); chk3("w3.fwd2", 3'b110, 3'd4, 1'b0); @(negedge clk);
        r3_rst = 1'b1; r3_ld = 1'b1; r3_lp = 3'd5;
        tick(); chk3("w3.rst_prio", 3'b011, 3'd2, 1'b0); @(negedge clk);
        r3_rst = 1'b0; r3_ld = 1'b0; r3_ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk3($sformatf("w3.hold%0d", i), 3'b011, 3'd2, 1'b0); @(negedge clk);
        end

        // Out-of-range loads clear the ring and pulse ERR once.
        r3_ld = 1'b1; r3_lp = 3'd6;
        tick(); chk3("w3.badload6", 3'b000, 3'd0, 1'b1); @(negedge clk);
        r3_ld = 1'b0;
        tick(); chk3("w3.after_bad", 3'b000, 3'd0, 1'b0); @(negedge clk);
        r3_ld = 1'b1; r3_lp = 3'd7; r3_ce = 1'b1;
        tick(); chk3("w3.badload7", 3'b000, 3'd0, 1'b1); @(negedge clk);

        // Reverse across phase 0, then forward back across the top.
        r3_ld = 1'b0; r3_ce = 1'b1; r3_up = 1'b0;
        #1; chk("w3.rev.WRAP", 32'(w3_wrap), 32'(1'b1));
        tick(); chk3("w3.rev", 3'b100, 3'd5, 1'b0); @(negedge clk);
        r3_up = 1'b1;
        #1; chk("w3.fwdtop.WRAP", 32'(w3_wrap), 32'(1'b1));
        tick(); chk3("w3.fwdtop", 3'b000, 3'd0, 1'b0); @(negedge clk);

        // Illegal ring state recovers on the next edge, overriding CE=0.
        r3_ce = 1'b0; r3_ld = 1'b1; r3_lp = 3'd4;
        tick(); chk3("w3.load4", 3'b110, 3'd4, 1'b0); @(negedge clk);
        r3_ld = 1'b0;
        force u_w3.r_o = 3'b101;
        #1;
        release u_w3.r_o;
        tick(); chk3("w3.recover", 3'b000, 3'd0, 1'b1); @(negedge clk);
        tick(); chk3("w3.recover_next", 3'b000, 3'd0, 1'b0); @(negedge clk);

        // Recovery also outranks a simultaneous legal load.
        force u_w3.r_o = 3'b010;
        #1;
        release u_w3.r_o;
        r3_ld = 1'b1; r3_lp = 3'd4; r3_ce = 1'b1;
        tick(); chk3("w3.recover_ld", 3'b000, 3'd0, 1'b1); @(negedge clk);
        r3_ld = 1'b0; r3_ce = 1'b0;

`ifdef JOHNSON_DECODE_EN
        // One-hot decode across a full forward cycle.
        r3_ld = 1'b1; r3_lp = 3'd0;
        tick(); @(negedge clk);
        r3_ld = 1'b0; r3_ce = 1'b1; r3_up = 1'b1;
        for (int p = 0; p < 6; p++) begin
            chk($sformatf("w3.dec%0d", p),    32'(w3_dec), 32'(1) << p);
            chk($sformatf("w3.onehot%0d", p), 32'($onehot(w3_dec)), 32'd1);
            tick(); @(negedge clk);
        end
        r3_ce = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
